// File: rtl/fifo_dot_accum.sv
// fifo_dot_accum: pops VEC_LEN packed int8x4 words from the activation FIFO,
// multiplies each lane by a latched int8 weight and accumulates one signed
// dot product, presented on a registered valid/ready output.
//
// Output handshake: o_result is meaningful whenever o_valid=1 and is held
// stable until a rising edge where o_valid=1 and i_ready=1; that edge is the
// transfer and o_valid drops on it. o_valid never drops without i_ready.
module fifo_dot_accum #(
    parameter int VEC_LEN = 4,
    parameter int ACC_W   = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [31:0]      i_weight,
    input  logic [31:0]      i_fifo_data,
    input  logic             i_fifo_empty,
    output logic             o_fifo_rd,
    output logic [ACC_W-1:0] o_result,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_busy
);

    localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [31:0]        weight_q;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;

    logic signed [15:0]      prod [4];
    logic signed [17:0]      word_sum;
    logic signed [ACC_W-1:0] word_sum_ext;
    logic [ACC_W-1:0]        acc_next;

    // Pop only while running and the FIFO has a word; no path from i_ready/i_start.
    assign o_fifo_rd = (state == RUN) && !i_fifo_empty;
    assign o_busy    = (state != IDLE);

    // Per-lane signed 8x8 products summed into one sign-extended word contribution.
    always_comb begin
        prod     = '{default: '0};
        word_sum = '0;
        for (int k = 0; k < 4; k++) begin
            prod[k]  = 16'($signed(i_fifo_data[8*k +: 8])) * 16'($signed(weight_q[8*k +: 8]));
            word_sum = word_sum + 18'(prod[k]);
        end
        word_sum_ext = ACC_W'(word_sum);
        acc_next     = acc + word_sum_ext;
    end

    // Control FSM plus accumulator, counter, weight and result registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            weight_q <= '0;
            acc      <= '0;
            cnt      <= '0;
            o_result <= '0;
            o_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        weight_q <= i_weight;
                        acc      <= '0;
                        cnt      <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (o_fifo_rd) begin
                        acc <= acc_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_IDX) begin
                            o_result <= acc_next;
                            o_valid  <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    o_valid <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_dot_accum.sv
// Bench for fifo_dot_accum: queue-based FIFO model, directed cases and a
// randomized run checked against an integer dot-product reference.
module tb_fifo_dot_accum;

    localparam int VEC_LEN = 4;
    localparam int ACC_W   = 32;

    // ---------------- clock / reset ----------------
    logic             i_clk = 1'b0;
    logic             i_rst;
    logic             i_start;
    logic [31:0]      i_weight;
    logic [31:0]      i_fifo_data  = 32'h0;
    logic             i_fifo_empty = 1'b1;
    logic             o_fifo_rd;
    logic [ACC_W-1:0] o_result;
    logic             o_valid;
    logic             i_ready;
    logic             o_busy;

    always #5 i_clk = ~i_clk;

    fifo_dot_accum #(.VEC_LEN(VEC_LEN), .ACC_W(ACC_W)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_weight     (i_weight),
        .i_fifo_data  (i_fifo_data),
        .i_fifo_empty (i_fifo_empty),
        .o_fifo_rd    (o_fifo_rd),
        .o_result     (o_result),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_busy       (o_busy)
    );

    // ---------------- scoreboard state ----------------
    logic [31:0]      fifo_q[$];
    logic [31:0]      push_q[$];
    logic [ACC_W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    int n_out = 0;
    int n_exp = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain signed integer dot product, wrapped to ACC_W bits.
    function automatic logic [ACC_W-1:0] dot_model(input logic [31:0] w, input logic [31:0] words [VEC_LEN]);
        longint s = 0;
        byte    a;
        byte    b;
        for (int i = 0; i < VEC_LEN; i++) begin
            for (int k = 0; k < 4; k++) begin
                a = words[i][8*k +: 8];
                b = w[8*k +: 8];
                s = s + longint'(a) * longint'(b);
            end
        end
        return ACC_W'(s);
    endfunction

    // FIFO model: pops on o_fifo_rd, then absorbs words queued by the driver.
    always @(posedge i_clk) begin
        if (i_rst) begin
            fifo_q.delete();
            push_q.delete();
        end else begin
            if (o_fifo_rd) begin
                check("pop_nonempty", 64'(fifo_q.size() != 0), 64'd1);
                if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            end
            while (push_q.size() != 0) fifo_q.push_back(push_q.pop_front());
        end
        i_fifo_empty <= (fifo_q.size() == 0);
        i_fifo_data  <= (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
    end

    // Output monitor: every valid cycle must match the oldest expected result.
    always begin
        @(negedge i_clk);
        #1;
        if (!i_rst && o_valid) begin
            check("result_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                check(i_ready ? "result" : "result_hold", 64'(o_result), 64'(exp_q[0]));
                if (i_ready) begin
                    void'(exp_q.pop_front());
                    n_out++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_words(input logic [31:0] w, input int n);
        repeat (n) push_q.push_back(w);
    endtask

    task automatic expect_result(input logic [ACC_W-1:0] r);
        exp_q.push_back(r);
        n_exp++;
    endtask

    task automatic start_vec(input logic [31:0] w);
        i_weight = w;
        i_start  = 1'b1;
        @(negedge i_clk);
        i_start  = 1'b0;
        i_weight = $urandom;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((o_busy || exp_q.size() != 0) && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        check(tag, 64'(n < 200), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 64'(o_valid), 64'd0);
        check({tag, "_result"}, 64'(o_result), 64'd0);
        check({tag, "_rd"}, 64'(o_fifo_rd), 64'd0);
        check({tag, "_busy"}, 64'(o_busy), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] w;
        logic [31:0] words [VEC_LEN];
        int          pre;
        int          idx;
        int          n;

        i_rst = 1'b1; i_start = 1'b0; i_ready = 1'b1; i_weight = 32'h0;
        #1;
        check_reset_outputs("rst_init");
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        repeat (3) @(negedge i_clk);

        // Asynchronous reset while idle: outputs low before any clock edge.
        #2 i_rst = 1'b1;
        #1 check_reset_outputs("rst_idle");
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);

        // Basic back-to-back vector: 4 pops in 4 cycles, 40, valid for 1 cycle.
        push_words(32'h01020304, 4);
        @(negedge i_clk);
        expect_result(32'd40);
        start_vec(32'h01010101);
        for (int i = 0; i < 4; i++) begin
            check("basic_rd", 64'(o_fifo_rd), 64'd1);
            @(negedge i_clk);
        end
        check("basic_valid", 64'(o_valid), 64'd1);
        check("basic_rd_done", 64'(o_fifo_rd), 64'd0);
        @(negedge i_clk);
        check("basic_valid_drop", 64'(o_valid), 64'd0);
        check("basic_idle", 64'(o_busy), 64'd0);

        // Signed extremes.
        push_words(32'h80808080, 4);
        @(negedge i_clk);
        expect_result(32'hFFFC0800);
        start_vec(32'h7F7F7F7F);
        wait_idle("signed_pos_neg");
        push_words(32'h80808080, 4);
        @(negedge i_clk);
        expect_result(32'd2048);
        start_vec(32'hFFFFFFFF);
        wait_idle("signed_neg_neg");

        // Empty stall: two words, three empty cycles, then the last two.
        push_words(32'h01020304, 2);
        @(negedge i_clk);
        expect_result(32'd40);
        start_vec(32'h01010101);
        for (int i = 0; i < 2; i++) begin
            check("stall_rd_pre", 64'(o_fifo_rd), 64'd1);
            @(negedge i_clk);
        end
        for (int g = 0; g < 3; g++) begin
            check("stall_rd_gap", 64'(o_fifo_rd), 64'd0);
            check("stall_busy", 64'(o_busy), 64'd1);
            if (g == 2) push_words(32'h01020304, 2);
            @(negedge i_clk);
        end
        wait_idle("stall_done");

        // Backpressure: hold i_ready low, poke i_start, offer a FIFO word.
        push_words(32'h01020304, 4);
        @(negedge i_clk);
        expect_result(32'd40);
        i_ready = 1'b0;
        start_vec(32'h01010101);
        n = 0;
        while (!o_valid && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        check("bp_valid_rise", 64'(o_valid), 64'd1);
        push_words(32'h01020304, 1);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid_hold", 64'(o_valid), 64'd1);
            check("bp_no_pop", 64'(o_fifo_rd), 64'd0);
            i_start  = 1'b1;
            i_weight = $urandom;
            @(negedge i_clk);
        end
        i_ready = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        check("bp_valid_drop", 64'(o_valid), 64'd0);
        check("bp_idle", 64'(o_busy), 64'd0);
        check("bp_fifo_level", 64'(fifo_q.size()), 64'd1);
        push_words(32'h01020304, 3);
        @(negedge i_clk);
        expect_result(32'd40);
        start_vec(32'h01010101);
        wait_idle("bp_followup");

        // Reset mid-run after two pops: abandoned, then a clean vector.
        push_words(32'h7F7F7F7F, 4);
        @(negedge i_clk);
        start_vec(32'h01010101);
        @(negedge i_clk);
        @(negedge i_clk);
        #2 i_rst = 1'b1;
        #1 check_reset_outputs("rst_run");
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        push_words(32'h01020304, 4);
        @(negedge i_clk);
        expect_result(32'd40);
        start_vec(32'h01010101);
        wait_idle("rst_run_fresh");

        // Randomized vectors with random FIFO gaps and backpressure.
        for (int v = 0; v < 25; v++) begin
            w = $urandom;
            for (int i = 0; i < VEC_LEN; i++) words[i] = $urandom;
            pre = $urandom_range(0, VEC_LEN);
            for (int i = 0; i < pre; i++) push_words(words[i], 1);
            @(negedge i_clk);
            expect_result(dot_model(w, words));
            start_vec(w);
            idx = pre;
            n   = 0;
            while ((o_busy || exp_q.size() != 0) && n < 300) begin
                i_ready = 1'($urandom_range(0, 1));
                if (idx < VEC_LEN && $urandom_range(0, 2) != 0) begin
                    push_words(words[idx], 1);
                    idx++;
                end
                @(negedge i_clk);
                n++;
            end
            check("rand_done", 64'(n < 300), 64'd1);
            i_ready = 1'b1;
        end

        repeat (3) @(negedge i_clk);
        check("exp_drained", 64'(exp_q.size()), 64'd0);
        check("result_count", 64'(n_out), 64'(n_exp));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_dot_accum.md
Name: fifo_dot_accum

Overview:
- Consumer stage directly downstream of the 32-bit activation FIFO.
- Each FIFO word packs four signed int8 activations. This block pops VEC_LEN words and multiplies each lane by a latched int8 weight.
- It accumulates the products into one signed dot-product result and presents it on a valid/ready output handshake.
- It reads the FIFO's combinational data and empty flag and drives the FIFO's read strobe.

Parameters:
- VEC_LEN, 4, number of FIFO words per dot product (must be >= 1).
- ACC_W, 32, accumulator/result width in bits (must be >= 18).

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_start  input  1  start one dot product; accepted only in IDLE.
- i_weight  input  32  four signed int8 weights, lane k = bits [8k+7:8k]; latched on accepted i_start.
- i_fifo_data  input  32  FIFO head word; valid whenever i_fifo_empty=0.
- i_fifo_empty  input  1  FIFO empty flag.
- o_fifo_rd  output  1  FIFO pop strobe (combinational).
- o_result  output  ACC_W  signed dot-product result (registered).
- o_valid  output  1  o_result valid.
- i_ready  input  1  downstream accepts o_result.
- o_busy  output  1  high in RUN and DONE.

Behaviour:
- Reset (i_rst=1, asynchronous):
  - state=IDLE; accumulator, word counter, weight register and o_result all cleared to 0.
  - o_valid=0, o_busy=0, o_fifo_rd=0.
  - Reset mid-RUN or mid-DONE abandons the operation. Any words already popped are lost; no partial result is emitted.
- State machine: IDLE, RUN, DONE.
- IDLE:
  - o_fifo_rd=0, o_valid=0.
  - On i_start=1: latch i_weight, clear accumulator and counter, go to RUN next edge.
- RUN:
  - o_fifo_rd = !i_fifo_empty. The block never pops an empty FIFO.
  - On each edge with o_fifo_rd=1:
    - compute p_k = signed(i_fifo_data lane k) * signed(weight lane k), each 16-bit signed;
    - sum the four p_k, sign-extend to ACC_W, add to the accumulator;
    - counter++.
  - Accumulation wraps modulo 2^ACC_W with no saturation.
  - Empty FIFO: no pop; accumulator and counter hold (stall of any length).
  - On the pop where counter == VEC_LEN-1:
    - o_result <= accumulator + this word's sum;
    - o_valid <= 1;
    - go to DONE.
  - Latency: o_valid rises on the edge that consumes the final word.
  - Throughput: one word per cycle while the FIFO is non-empty. A back-to-back VEC_LEN=4 vector completes in 4 RUN cycles.
- DONE:
  - o_fifo_rd=0; o_valid=1; o_result held stable.
  - When i_ready=1: o_valid <= 0, go to IDLE.
  - i_ready low for any number of cycles: output holds, no pops.
- Ignored inputs:
  - i_start is ignored in RUN and DONE, including the DONE cycle where i_ready=1. A new start is accepted only once state=IDLE.
  - i_weight changes outside an accepted start have no effect.
- o_busy = (state != IDLE).
- o_fifo_rd depends only on state and i_fifo_empty; there is no combinational path from i_ready or i_start.

Test Plan:
- Reset: assert i_rst for 2 cycles mid-idle -> o_valid=0, o_result=0, o_fifo_rd=0, o_busy=0 immediately, without waiting for a clock edge.
- Basic, VEC_LEN=4:
  - Stimulus: i_weight=0x01010101; FIFO preloaded with 4× 0x01020304; i_start pulse; i_ready=1.
  - Response: o_fifo_rd high 4 consecutive cycles; o_result=40 (0x28) with o_valid high for 1 cycle; then IDLE.
- Signed arithmetic:
  - i_weight=0x7F7F7F7F, 4× words 0x80808080 -> o_result=0xFFFC0800 (-260096).
  - i_weight=0xFFFFFFFF, same words -> o_result=2048.
- Empty stall: basic case, but the FIFO holds only 2 words, then stays empty 3 cycles before words 3–4 are written -> o_fifo_rd=0 during the gap, no FIFO underflow, o_result=40.
- Backpressure:
  - Hold i_ready=0 for 5 cycles after o_valid rises -> o_result=40 stable, o_valid=1, no pops, i_start pulses ignored.
  - Then i_ready=1 -> o_valid=0 next edge, o_busy=0.
- Reset mid-run: assert i_rst after 2 pops -> IDLE immediately, o_fifo_rd=0. A fresh start with 4 new 0x01020304 words yields exactly 40.
